// File: rtl/seg7_scroll_if.sv
// Avalon-MM slave bus bundle for the 7-segment scroll sequencer.
interface seg7_scroll_if;
  logic [1:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;

  modport master (
    output address, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/seg7_scroll_ctrl.sv
// Scrolls a 16-nibble message through a six-digit hex 7-segment display.
// Define SEG7_SCROLL_IRQ_EN to enable the sticky pass-complete interrupt.
module seg7_scroll_ctrl #(
  parameter int unsigned DEFAULT_PERIOD = 32'd25000000,
  parameter int unsigned MIN_PERIOD     = 32'd2
) (
  input  logic         clk,
  input  logic         reset,
  seg7_scroll_if.slave avs,
  output logic         seg_write,
  output logic [31:0]  seg_writedata,
  output logic         irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        run_q, run_d;
  logic        loop_q, loop_d;
  logic        dir_q, dir_d;
  logic [4:0]  len_q, len_d;
  logic [31:0] period_q, period_d;
  logic [63:0] msg_q, msg_d;
  logic [3:0]  pos_q, pos_d;
  logic        done_q, done_d;
  logic [31:0] cnt_q, cnt_d;
  logic        seg_wr_q, seg_wr_d;
  logic [23:0] seg_data_q, seg_data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;

  logic        ctrl_wr;
  logic        wr_run;
  logic        wr_stop;
  logic        wr_refresh;
  logic        expire;
  logic        pass_set;
  logic        busy;
  logic [4:0]  len_eff;
  logic [4:0]  pos_cur;
  logic [3:0]  pos_nxt;
  logic [4:0]  idx [6];
  logic [23:0] window;

  assign ctrl_wr    = avs.write && (avs.address == 2'd0);
  assign wr_run     = ctrl_wr && avs.writedata[0];
  assign wr_stop    = ctrl_wr && !avs.writedata[0];
  assign wr_refresh = wr_stop && avs.writedata[3];
  assign busy       = (state_q != S_IDLE);
  assign expire     = (cnt_q <= 32'd1);

  always_comb begin
    len_eff = len_q;
    if (len_q < 5'd6) begin
      len_eff = 5'd6;
    end else if (len_q > 5'd16) begin
      len_eff = 5'd16;
    end
  end

  // pos may exceed a freshly shortened len; fold it before use
  assign pos_cur = {1'b0, pos_q} % len_eff;

  always_comb begin
    pos_nxt = 4'd0;
    if (!dir_q) begin
      if (pos_cur + 5'd1 != len_eff) begin
        pos_nxt = 4'(pos_cur + 5'd1);
      end
    end else if (pos_cur == 5'd0) begin
      pos_nxt = 4'(len_eff - 5'd1);
    end else begin
      pos_nxt = 4'(pos_cur - 5'd1);
    end
  end

  assign pass_set = (state_q == S_WAIT) && expire &&
                    !wr_stop && (pos_nxt == 4'd0);

  // len_eff >= 6 keeps pos+5 below 2*len, so one fold suffices
  always_comb begin
    window = '0;
    for (int k = 0; k < 6; k++) begin
      idx[k] = pos_cur + 5'd5 - 5'(k);
      if (idx[k] >= len_eff) begin
        idx[k] = idx[k] - len_eff;
      end
      window[4*k +: 4] = msg_q[{idx[k][3:0], 2'b00} +: 4];
    end
  end

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    loop_d     = loop_q;
    dir_d      = dir_q;
    len_d      = len_q;
    period_d   = period_q;
    msg_d      = msg_q;
    pos_d      = pos_q;
    done_d     = done_q;
    cnt_d      = cnt_q;
    seg_wr_d   = 1'b0;
    seg_data_d = seg_data_q;
    rdata_d    = rdata_q;
    irq_d      = irq_q;

    if (avs.write) begin
      unique case (avs.address)
        2'd0: begin
          run_d  = avs.writedata[0];
          loop_d = avs.writedata[1];
          dir_d  = avs.writedata[2];
          len_d  = avs.writedata[8:4];
        end
        2'd1: begin
          period_d = (avs.writedata < MIN_PERIOD) ?
                     MIN_PERIOD : avs.writedata;
        end
        2'd2: msg_d[31:0]  = avs.writedata;
        2'd3: msg_d[63:32] = avs.writedata;
      endcase
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (wr_run) begin
          pos_d   = 4'd0;
          done_d  = 1'b0;
          state_d = S_UPDATE;
        end else if (wr_refresh) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (wr_stop) begin
          state_d = S_IDLE;
        end else begin
          seg_wr_d   = 1'b1;
          seg_data_d = window;
          if (run_q) begin
            cnt_d   = period_q - 32'd1;
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        if (wr_stop) begin
          state_d = S_IDLE;
        end else if (expire) begin
          pos_d   = pos_nxt;
          state_d = S_UPDATE;
          if (pass_set && !loop_q) begin
            state_d = S_DONE;
            pos_d   = 4'd0;
            run_d   = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
    endcase

    if (avs.read) begin
      unique case (avs.address)
        2'd0: rdata_d = {irq_q, 3'b000, pos_q, 6'b000000,
                         done_q, busy, 7'b0000000, len_q,
                         1'b0, dir_q, loop_q, run_q};
        2'd1: rdata_d = period_q;
        2'd2: rdata_d = msg_q[31:0];
        2'd3: rdata_d = msg_q[63:32];
      endcase
    end

`ifdef SEG7_SCROLL_IRQ_EN
    if (pass_set) begin
      irq_d = 1'b1;
    end
    if (ctrl_wr && avs.writedata[31]) begin
      irq_d = 1'b0;
    end
`else
    irq_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      run_q      <= 1'b0;
      loop_q     <= 1'b0;
      dir_q      <= 1'b0;
      len_q      <= 5'd0;
      period_q   <= DEFAULT_PERIOD;
      msg_q      <= 64'd0;
      pos_q      <= 4'd0;
      done_q     <= 1'b0;
      cnt_q      <= 32'd0;
      seg_wr_q   <= 1'b0;
      seg_data_q <= 24'd0;
      rdata_q    <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      loop_q     <= loop_d;
      dir_q      <= dir_d;
      len_q      <= len_d;
      period_q   <= period_d;
      msg_q      <= msg_d;
      pos_q      <= pos_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      seg_wr_q   <= seg_wr_d;
      seg_data_q <= seg_data_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign avs.readdata  = rdata_q;
  assign seg_write     = seg_wr_q;
  assign seg_writedata = {8'h00, seg_data_q};
  assign irq           = irq_q;

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// Scoreboard bench for seg7_scroll_ctrl: expected windows are queued
// at stimulus time and popped on every seg_write pulse.
module tb_seg7_scroll_ctrl;
  localparam int unsigned DEF_PERIOD = 25000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        seg_write;
  logic [31:0] seg_writedata;
  logic        irq;

  seg7_scroll_if bus();

  seg7_scroll_ctrl #(
    .DEFAULT_PERIOD(DEF_PERIOD),
    .MIN_PERIOD(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .avs(bus),
    .seg_write(seg_write),
    .seg_writedata(seg_writedata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          pulses = 0;
  int          last_cyc = 0;
  int          first_cyc = 0;
  int          exp_gap = 0;
  bit          have_last = 1'b0;
  logic [23:0] exp_q[$];
  logic [63:0] msg = '0;
  logic [31:0] rd;
  logic [31:0] exp_irq;
  int          t0;
  int          p0;
  int          n;
  bit          found;

  logic [23:0] t2_exp [8] = '{
    24'h012345, 24'h123456, 24'h234567, 24'h345670,
    24'h456701, 24'h567012, 24'h670123, 24'h701234
  };

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] win(input logic [63:0] m,
                                      input int p, input int l);
    logic [23:0] r = '0;
    for (int k = 5; k >= 0; k--) begin
      r = {r[19:0], m[((p + 5 - k) % l) * 4 +: 4]};
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (seg_write === 1'b1) begin
      pulses++;
      if (!have_last) first_cyc = cyc;
      else if (exp_gap != 0) chk("gap", cyc - last_cyc, exp_gap);
      have_last = 1'b1;
      last_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_pulse", {31'b0, seg_write}, 0);
      else chk("window", seg_writedata, {8'h00, exp_q.pop_front()});
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    bus.writedata = d;
    bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    d = bus.readdata;
  endtask

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic arm(input int gap);
    exp_gap = gap;
    have_last = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int w = 0;
    while (exp_q.size() != 0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.address = '0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.writedata = '0;
`ifdef SEG7_SCROLL_IRQ_EN
    exp_irq = 32'd1;
`else
    exp_irq = 32'd0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    bus_read(2'd0, rd); chk("rst_ctrl", rd, 0);
    bus_read(2'd1, rd); chk("rst_period", rd, DEF_PERIOD);
    bus_read(2'd2, rd); chk("rst_msg_lo", rd, 0);
    bus_read(2'd3, rd); chk("rst_msg_hi", rd, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    chk("rst_segdata", seg_writedata, 0);
    idle(100);
    chk("rst_no_pulse", pulses, 0);

    // one pass left, len 8
    msg = 64'h0000_0000_7654_3210;
    bus_write(2'd2, msg[31:0]);
    bus_write(2'd1, 32'd4);
    foreach (t2_exp[i]) exp_q.push_back(t2_exp[i]);
    arm(4);
    p0 = pulses;
    bus_write(2'd0, 32'h081);
    t0 = cyc;
    wait_drain("t2_drain", 100);
    chk("t2_latency", first_cyc - t0, 1);
    idle(20);
    chk("t2_count", pulses - p0, 8);
    bus_read(2'd0, rd);
    chk("t2_status", rd & 32'h0F03_0007, 32'h0002_0000);

    // loop right, len 8
    for (int i = 0; i < 10; i++) begin
      if (i == 0) exp_q.push_back(24'h012345);
      else if (i == 1) exp_q.push_back(24'h701234);
      else if (i == 2) exp_q.push_back(24'h670123);
      else exp_q.push_back(win(msg, (8 - i % 8) % 8, 8));
    end
    arm(4);
    bus_write(2'd0, 32'h087);
    wait_drain("t3_drain", 100);
    exp_q.push_back(win(msg, 6, 8));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      found = (seg_write === 1'b1);
    end
    chk("t3_sync", {31'b0, found}, 1);
    // stop write lands on the countdown expiry edge
    repeat (3) @(negedge clk);
    bus.address = 2'd0;
    bus.writedata = 32'd0;
    bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    chk("t3_busy", bus.readdata & 32'h0001_0001, 0);
    p0 = pulses;
    idle(30);
    chk("t3_no_pulse", pulses - p0, 0);

    // period 1 clamps to 2, len 3 acts as 6
    msg = 64'hFEDC_BA98_7654_3210;
    bus_write(2'd3, msg[63:32]);
    bus_write(2'd1, 32'd1);
    for (int i = 0; i < 6; i++) exp_q.push_back(win(msg, i, 6));
    arm(2);
    p0 = pulses;
    bus_write(2'd0, 32'h031);
    wait_drain("t4_drain", 60);
    idle(10);
    chk("t4_count", pulses - p0, 6);
    bus_read(2'd0, rd);
    chk("t4_len_raw", (rd >> 4) & 32'h1F, 3);
    chk("t4_done", rd & 32'h0003_0001, 32'h0002_0000);

    // period 0 clamps to 2, len 20 acts as 16
    bus_write(2'd1, 32'd0);
    for (int i = 0; i < 16; i++) exp_q.push_back(win(msg, i, 16));
    arm(2);
    p0 = pulses;
    bus_write(2'd0, 32'h141);
    wait_drain("t5_drain", 120);
    idle(10);
    chk("t5_count", pulses - p0, 16);
    bus_read(2'd0, rd);
    chk("t5_len_raw", (rd >> 4) & 32'h1F, 20);

    // refresh while idle: one update with the new message
    msg[31:0] = 32'h89AB_CDEF;
    bus_write(2'd2, msg[31:0]);
    exp_q.push_back(win(msg, 0, 8));
    arm(0);
    p0 = pulses;
    bus_write(2'd0, 32'h088);
    wait_drain("t6_drain", 20);
    idle(20);
    chk("t6_count", pulses - p0, 1);
    bus_read(2'd0, rd);
    chk("t6_idle", rd & 32'h0001_0009, 0);

    // pass-complete interrupt
    bus_write(2'd0, 32'h8000_0000);
    idle(2);
    chk("t7_irq_pre", {31'b0, irq}, 0);
    bus_write(2'd1, 32'd4);
    for (int i = 0; i < 6; i++) exp_q.push_back(win(msg, i, 6));
    arm(4);
    bus_write(2'd0, 32'h061);
    n = 0;
    while (exp_q.size() > 1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t7_irq_mid", {31'b0, irq}, 0);
    wait_drain("t7_drain", 20);
    idle(10);
    chk("t7_irq_set", {31'b0, irq}, exp_irq);
    bus_read(2'd0, rd);
    chk("t7_ctrl31", {31'b0, rd[31]}, exp_irq);
    bus_write(2'd0, 32'h8000_0000);
    idle(1);
    chk("t7_irq_clr", {31'b0, irq}, 0);

    // reset in the middle of a looping run
    exp_q.push_back(win(msg, 0, 8));
    exp_q.push_back(win(msg, 1, 8));
    arm(4);
    bus_write(2'd0, 32'h083);
    wait_drain("t8_drain", 40);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    p0 = pulses;
    chk("t8_seg_write", {31'b0, seg_write}, 0);
    bus_read(2'd0, rd); chk("t8_ctrl", rd, 0);
    bus_read(2'd1, rd); chk("t8_period", rd, DEF_PERIOD);
    bus_read(2'd2, rd); chk("t8_msg_lo", rd, 0);
    idle(30);
    chk("t8_no_pulse", pulses - p0, 0);
    chk("t8_segdata", seg_writedata, 0);
    chk("t8_irq", {31'b0, irq}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
